// File: rtl/display_scan_driver_pkg.sv
// Segment bit positions and hex glyph constants for the multiplexed display driver.
// Glyphs are active-high, seg[6]=a down to seg[0]=g; polarity is applied at the top level.
package display_scan_driver_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam seg_t BIT_A = seg_t'(1 << SEG_A);
    localparam seg_t BIT_B = seg_t'(1 << SEG_B);
    localparam seg_t BIT_C = seg_t'(1 << SEG_C);
    localparam seg_t BIT_D = seg_t'(1 << SEG_D);
    localparam seg_t BIT_E = seg_t'(1 << SEG_E);
    localparam seg_t BIT_F = seg_t'(1 << SEG_F);
    localparam seg_t BIT_G = seg_t'(1 << SEG_G);

    localparam seg_t SEG_OFF = 7'h00;
    localparam seg_t SEG_0 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F;
    localparam seg_t SEG_1 = BIT_B | BIT_C;
    localparam seg_t SEG_2 = BIT_A | BIT_B | BIT_D | BIT_E | BIT_G;
    localparam seg_t SEG_3 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_G;
    localparam seg_t SEG_4 = BIT_B | BIT_C | BIT_F | BIT_G;
    localparam seg_t SEG_5 = BIT_A | BIT_C | BIT_D | BIT_F | BIT_G;
    localparam seg_t SEG_6 = BIT_A | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
    localparam seg_t SEG_7 = BIT_A | BIT_B | BIT_C;
    localparam seg_t SEG_8 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
    localparam seg_t SEG_9 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_F | BIT_G;
    localparam seg_t SEG_HEX_A = BIT_A | BIT_B | BIT_C | BIT_E | BIT_F | BIT_G;
    localparam seg_t SEG_HEX_B = BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
    localparam seg_t SEG_HEX_C = BIT_A | BIT_D | BIT_E | BIT_F;
    localparam seg_t SEG_HEX_D = BIT_B | BIT_C | BIT_D | BIT_E | BIT_G;
    localparam seg_t SEG_HEX_E = BIT_A | BIT_D | BIT_E | BIT_F | BIT_G;
    localparam seg_t SEG_HEX_F = BIT_A | BIT_E | BIT_F | BIT_G;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to 7-segment glyph, active-high.
// Latency: combinational. Backpressure: none.
// Polarity and blanking are the caller's concern.
module seg7_hex_decode
    import display_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed hex display scanner with blink and leading-zero suppression.
// Latency: seg/an registered, 1 clk after index/shadow state.
// Backpressure: none; free-running scan, load captures unconditionally.
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lzs,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
    localparam logic          INVERT   = (ACTIVE_LOW != 0);

    localparam seg_t                SEG_IDLE = INVERT ? ~SEG_OFF : SEG_OFF;
    localparam logic [N_DIGITS-1:0] AN_IDLE  = INVERT ? '1 : '0;

    logic [PW-1:0]         ps_cnt;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         blk_cnt;
    logic                  blink_phase;
    logic [4*N_DIGITS-1:0] data_sh;
    logic [N_DIGITS-1:0]   mask_sh;
    logic                  lzs_sh;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nibble;
    logic                  mask_bit;
    logic                  lead_zero;
    logic                  run_zero;
    logic                  blank;
    seg_t                  glyph;
    seg_t                  seg_act;
    logic [N_DIGITS-1:0]   an_act;

    assign tick = (ps_cnt == PS_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Walk from the most significant digit down so run_zero tells whether
    // everything at and above digit i is zero.
    always_comb begin
        nibble    = 4'h0;
        mask_bit  = 1'b0;
        lead_zero = 1'b0;
        run_zero  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero && (data_sh[i*4 +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                nibble    = data_sh[i*4 +: 4];
                mask_bit  = mask_sh[i];
                lead_zero = run_zero && (i != 0);
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_comb begin
        blank   = (mask_bit && blink_phase) || (lzs_sh && lead_zero);
        seg_act = blank ? SEG_OFF : glyph;
        an_act  = N_DIGITS'(1) << idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_cnt      <= '0;
            idx         <= '0;
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
            data_sh     <= '0;
            mask_sh     <= '0;
            lzs_sh      <= 1'b0;
            frame       <= 1'b0;
            seg         <= SEG_IDLE;
            an          <= AN_IDLE;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            frame <= wrap;
            if (wrap) begin
                if (blk_cnt == BLK_LAST) begin
                    blk_cnt     <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
            if (load) begin
                data_sh <= data;
                mask_sh <= blink_mask;
                lzs_sh  <= lzs;
            end
            seg <= INVERT ? ~seg_act : seg_act;
            an  <= INVERT ? ~an_act : an_act;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: directed phases plus random loads, checked every
// cycle against a model derived from elapsed cycles since reset.
module tb_display_scan_driver;

    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [15:0]   data;
    logic [3:0]    blink_mask;
    logic          lzs;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          frame;

    always #5 clk = ~clk;

    display_scan_driver #(
        .N_DIGITS   (N),
        .SCAN_DIV   (S),
        .BLINK_DIV  (B),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data       (data),
        .blink_mask (blink_mask),
        .lzs        (lzs),
        .seg        (seg),
        .an         (an),
        .frame      (frame)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edges since reset plus the captured display registers.
    int          e = 0;
    logic [15:0] sh_data = '0;
    logic [3:0]  sh_mask = '0;
    logic        sh_lzs  = 1'b0;

    string glyph_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                                "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                                "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph(input logic [3:0] v);
        string      s;
        logic [6:0] g;
        int         pos;
        s = glyph_names[v];
        g = 7'h00;
        for (int k = 0; k < s.len(); k++) begin
            pos = 6 - (int'(s[k]) - 97);
            g[pos] = 1'b1;
        end
        return g;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic step();
        logic [6:0] es;
        logic [3:0] ea;
        logic       ef;
        int         di;
        int         frames;
        logic       ph;
        logic       blank;
        @(posedge clk);
        if (!rst_n) begin
            es = 7'h7F;
            ea = 4'hF;
            ef = 1'b0;
            e = 0;
            sh_data = '0;
            sh_mask = '0;
            sh_lzs  = 1'b0;
        end else begin
            di     = (e / S) % N;
            frames = e / (S * N);
            ph     = ((frames / B) % 2) == 1;
            blank  = (sh_mask[di] && ph) ||
                     (sh_lzs && di != 0 && (sh_data >> (4 * di)) == 16'h0);
            es = blank ? 7'h7F : ~glyph(sh_data[di*4 +: 4]);
            ea = ~(4'b0001 << di);
            ef = ((e + 1) % (S * N)) == 0;
            if (load) begin
                sh_data = data;
                sh_mask = blink_mask;
                sh_lzs  = lzs;
            end
            e++;
        end
        #1;
        check("seg", 32'(seg), 32'(es));
        check("an", 32'(an), 32'(ea));
        check("frame", 32'(frame), 32'(ef));
    endtask

    task automatic load_step(input logic [15:0] d, input logic [3:0] m, input logic z);
        data = d;
        blink_mask = m;
        lzs = z;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        data = '0;
        blink_mask = '0;
        lzs = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Idle display after release, then the basic 0x1234 scan.
        repeat (5) step();
        load_step(16'h1234, 4'b0000, 1'b0);
        repeat (40) step();

        // Leading-zero suppression on 0x0050 and on all-zero data.
        load_step(16'h0050, 4'b0000, 1'b1);
        repeat (20) step();
        load_step(16'h0000, 4'b0000, 1'b1);
        repeat (20) step();

        // Blink on digit 0 across several blink windows.
        load_step(16'h8888, 4'b0001, 1'b0);
        repeat (96) step();

        // Load landing on the same edge as a tick.
        while ((e % S) != S - 1) step();
        load_step(16'hABCD, 4'b0000, 1'b0);
        repeat (20) step();

        // Random loads with zero-heavy nibbles.
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] d;
                d = 16'($urandom);
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 1) == 1) d[k*4 +: 4] = 4'h0;
                end
                load_step(d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else begin
                step();
            end
        end

        // One-cycle reset mid-frame with a competing load.
        while ((e % (S * N)) != 6) step();
        rst_n = 1'b0;
        load_step(16'hFFFF, 4'hF, 1'b1);
        rst_n = 1'b1;
        repeat (24) step();

        // Every glyph on digit 0.
        for (int v = 0; v < 16; v++) begin
            load_step(16'(v), 4'b0000, 1'b0);
            repeat (S * N) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
